// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
package mips_muldiv_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    // wr_en bit positions
    localparam int WR_HI = 1;
    localparam int WR_LO = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // MULT and DIV (op[0] = 0) are the signed variants
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mips_muldiv_sign.sv
// rtl/mips_muldiv_sign.sv - combinational conditional two's-complement negate
// Ports:
//   val_i  in  WIDTH  value to pass through or negate
//   neg_i  in  1      1 = negate, 0 = pass through
//   res_o  out WIDTH  result; with neg_i = sign bit this is |val_i| as an unsigned value
module mips_muldiv_sign #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign res_o = neg_i ? (~val_i + ONE) : val_i;

endmodule

// File: rtl/mips_muldiv.sv
// rtl/mips_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO write port
// Optional feature macro: MIPS_MULDIV_EARLY_EN (multiply exits CALC once remaining multiplier bits are zero).
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   start, op          launch an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), taken only when idle
//   src_a, src_b       multiplicand/dividend and multiplier/divisor
//   mt_en, mt_data     MTLO (bit0) / MTHI (bit1) forwarding, honoured only when idle without start
//   busy               operation in flight (registered)
//   wr_en              HI/LO write enables (bit1 HI, bit0 LO), one-cycle pulse
//   wr_hdata, wr_ldata HI and LO write data
module mips_muldiv
    import mips_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [1:0]  mt_en,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic [1:0]  wr_en,
    output logic [31:0] wr_hdata,
    output logic [31:0] wr_ldata
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    // Multiply: 64-bit product accumulator. Divide: {remainder, dividend/quotient}.
    logic [63:0]        acc_q, acc_d;
    logic               sgn_lo_q, sgn_lo_d;   // product / quotient sign
    logic               sgn_hi_q, sgn_hi_d;   // remainder sign
    logic               busy_q;
    logic [1:0]         wr_en_q, wr_en_d;
    logic [31:0]        wr_h_q, wr_h_d;
    logic [31:0]        wr_l_q, wr_l_d;

    // The two 32-bit helpers take absolute values of the operands in PREP and
    // are reused to sign-fix remainder (HI) and quotient (LO) in FIX.
    logic        in_fix;
    logic [31:0] sa_val, sb_val, sa_res, sb_res;
    logic        sa_neg, sb_neg;
    logic [63:0] prod_res;

    assign in_fix = (state_q == S_FIX);
    assign sa_val = in_fix ? acc_q[63:32] : a_q;
    assign sa_neg = in_fix ? sgn_hi_q : (op_is_signed(op_q) & a_q[31]);
    assign sb_val = in_fix ? acc_q[31:0] : b_q;
    assign sb_neg = in_fix ? sgn_lo_q : (op_is_signed(op_q) & b_q[31]);

    mips_muldiv_sign #(.WIDTH(32)) u_sign_a (.val_i(sa_val), .neg_i(sa_neg), .res_o(sa_res));
    mips_muldiv_sign #(.WIDTH(32)) u_sign_b (.val_i(sb_val), .neg_i(sb_neg), .res_o(sb_res));
    mips_muldiv_sign #(.WIDTH(64)) u_sign_p (.val_i(acc_q),  .neg_i(sgn_lo_q), .res_o(prod_res));

    // One multiply step: multiplier is shifted right each iteration, the
    // multiplicand is aligned by the iteration count.
    logic [63:0] mul_add;
    assign mul_add = acc_q + ({32'd0, a_q} << cnt_q);

    // One restoring-divide step; 34 bits so the borrow is an unambiguous sign.
    logic [33:0] div_trial;
    assign div_trial = {1'b0, acc_q[63:31]} - {2'b00, b_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sgn_lo_d = sgn_lo_q;
        sgn_hi_d = sgn_hi_q;
        wr_en_d  = 2'b00;
        wr_h_d   = wr_h_q;
        wr_l_d   = wr_l_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = src_a;
                    b_d     = src_b;
                    state_d = S_PREP;
                end else if (mt_en != 2'b00) begin
                    wr_en_d = mt_en;
                    wr_h_d  = mt_data;
                    wr_l_d  = mt_data;
                end
            end
            S_PREP: begin
                a_d      = sa_res;
                b_d      = sb_res;
                sgn_lo_d = op_is_signed(op_q) & (a_q[31] ^ b_q[31]);
                sgn_hi_d = op_is_signed(op_q) & a_q[31];
                acc_d    = op_is_div(op_q) ? {32'd0, sa_res} : 64'd0;
                cnt_d    = '0;
                state_d  = S_CALC;
`ifdef MIPS_MULDIV_EARLY_EN
                if (!op_is_div(op_q) && sb_res == 32'd0) begin
                    state_d = S_FIX;
                end
`endif
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_is_div(op_q)) begin
                    if (!div_trial[33]) begin
                        acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[62:0], 1'b0};
                    end
                end else begin
                    if (b_q[0]) begin
                        acc_d = mul_add;
                    end
                    b_d = {1'b0, b_q[31:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
`ifdef MIPS_MULDIV_EARLY_EN
                if (!op_is_div(op_q) && b_q[31:1] == 31'd0) begin
                    state_d = S_FIX;
                end
`endif
            end
            S_FIX: begin
                cnt_d   = '0;
                wr_en_d = 2'b11;
                if (op_is_div(op_q)) begin
                    wr_h_d = sa_res;
                    wr_l_d = sb_res;
                end else begin
                    wr_h_d = prod_res[63:32];
                    wr_l_d = prod_res[31:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 2'b00;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            sgn_lo_q <= 1'b0;
            sgn_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            wr_en_q  <= 2'b00;
            wr_h_q   <= 32'd0;
            wr_l_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sgn_lo_q <= sgn_lo_d;
            sgn_hi_q <= sgn_hi_d;
            busy_q   <= (state_d != S_IDLE);
            wr_en_q  <= wr_en_d;
            wr_h_q   <= wr_h_d;
            wr_l_q   <= wr_l_d;
        end
    end

    assign busy     = busy_q;
    assign wr_en    = wr_en_q;
    assign wr_hdata = wr_h_q;
    assign wr_ldata = wr_l_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb/tb_mips_muldiv.sv - directed self-checking bench for mips_muldiv
module tb_mips_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [1:0]  mt_en;
    logic [31:0] mt_data;
    logic        busy;
    logic [1:0]  wr_en;
    logic [31:0] wr_hdata;
    logic [31:0] wr_ldata;

    int tests_run    = 0;
    int tests_failed = 0;

    mips_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .mt_en    (mt_en),
        .mt_data  (mt_data),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_hdata (wr_hdata),
        .wr_ldata (wr_ldata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op and watch 45 post-edge samples. lat is the sample index
    // (1 = first cycle after the accepting edge) of the first write pulse.
    // A stray start plus MT write is injected at sample stray_at (0 = none).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int stray_at,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int lat, output int busy_n, output int pulses);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busy_n = 0; pulses = 0; hi = 32'd0; lo = 32'd0;
        for (int k = 1; k <= 45; k++) begin
            if (busy) busy_n++;
            if (wr_en != 2'b00) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; hi = wr_hdata; lo = wr_ldata;
                end
            end
            if (k == stray_at) begin
                start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
                mt_en = 2'b11; mt_data = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; mt_en = 2'b00;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mt_en = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (wr_en !== 2'b00) begin tests_failed++; $display("FAIL reset_wr_en: got %b expected 00", wr_en); end
        tests_run++;
        if (wr_hdata !== 32'd0 || wr_ldata !== 32'd0) begin
            tests_failed++; $display("FAIL reset_data: got %h/%h expected 0/0", wr_hdata, wr_ldata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multu_max();
        logic [31:0] hi, lo; int lat, bn, np;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, hi, lo, lat, bn, np);
        tests_run++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            tests_failed++; $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", hi, lo);
        end
        tests_run++;
        if (lat !== 35) begin tests_failed++; $display("FAIL multu_latency: got %0d expected 35", lat); end
        tests_run++;
        if (bn !== 35) begin tests_failed++; $display("FAIL multu_busy_cycles: got %0d expected 35", bn); end
        tests_run++;
        if (np !== 1) begin tests_failed++; $display("FAIL multu_pulses: got %0d expected 1", np); end
    endtask

    task automatic test_mult_signed();
        logic [31:0] hi, lo; int lat, bn, np;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, hi, lo, lat, bn, np);
        tests_run++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || lat !== 35) begin
            tests_failed++; $display("FAIL mult_neg3x7: got %h_%h lat %0d expected ffffffff_ffffffeb lat 35", hi, lo, lat);
        end
    endtask

    task automatic test_div_signed();
        logic [31:0] hi, lo; int lat, bn, np;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, hi, lo, lat, bn, np);
        tests_run++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL div_neg7by2: got lo %h hi %h expected lo fffffffd hi ffffffff", lo, hi);
        end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, hi, lo, lat, bn, np);
        tests_run++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0000_0000 || lat !== 35) begin
            tests_failed++; $display("FAIL div_min_by_neg1: got lo %h hi %h lat %0d expected lo 80000000 hi 0 lat 35", lo, hi, lat);
        end
    endtask

    task automatic test_divu();
        logic [31:0] hi, lo; int lat, bn, np;
        run_op(2'b11, 32'd5, 32'd0, 0, hi, lo, lat, bn, np);
        tests_run++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_0005) begin
            tests_failed++; $display("FAIL divu_by_zero: got lo %h hi %h expected lo ffffffff hi 00000005", lo, hi);
        end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, hi, lo, lat, bn, np);
        tests_run++;
        if (lo !== 32'h0000_0000 || hi !== 32'h8000_0000) begin
            tests_failed++; $display("FAIL divu_big: got lo %h hi %h expected lo 00000000 hi 80000000", lo, hi);
        end
        run_op(2'b11, 32'd100, 32'd7, 0, hi, lo, lat, bn, np);
        tests_run++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            tests_failed++; $display("FAIL divu_100by7: got lo %h hi %h expected lo 0000000e hi 00000002", lo, hi);
        end
    endtask

    task automatic test_mt();
        mt_en = 2'b01; mt_data = 32'h0000_1234;
        @(posedge clk); #1;
        mt_en = 2'b00;
        tests_run++;
        if (wr_en !== 2'b01 || wr_ldata !== 32'h0000_1234 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL mtlo: got wr_en %b lo %h busy %b expected 01 00001234 0", wr_en, wr_ldata, busy);
        end
        mt_en = 2'b10; mt_data = 32'hCAFE_0001;
        @(posedge clk); #1;
        mt_en = 2'b00;
        tests_run++;
        if (wr_en !== 2'b10 || wr_hdata !== 32'hCAFE_0001) begin
            tests_failed++; $display("FAIL mthi: got wr_en %b hi %h expected 10 cafe0001", wr_en, wr_hdata);
        end
        @(posedge clk); #1;
        tests_run++;
        if (wr_en !== 2'b00) begin tests_failed++; $display("FAIL mt_single_pulse: got %b expected 00", wr_en); end
    endtask

    task automatic test_start_wins();
        int lat;
        start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
        mt_en = 2'b11; mt_data = 32'h5555_5555;
        @(posedge clk); #1;
        start = 1'b0; mt_en = 2'b00;
        tests_run++;
        if (wr_en !== 2'b00 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL start_wins: got wr_en %b busy %b expected 00 1", wr_en, busy);
        end
        lat = -1;
        for (int k = 2; k <= 45 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (wr_en != 2'b00) lat = k;
        end
        tests_run++;
        if (lat !== 35 || wr_en !== 2'b11 || wr_hdata !== 32'd0 || wr_ldata !== 32'd12) begin
            tests_failed++; $display("FAIL start_wins_result: got lat %0d wr_en %b %h_%h expected 35 11 00000000_0000000c", lat, wr_en, wr_hdata, wr_ldata);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo; int lat, bn, np;
        run_op(2'b01, 32'd6, 32'd9, 10, hi, lo, lat, bn, np);
        tests_run++;
        if (np !== 1 || hi !== 32'd0 || lo !== 32'd54 || bn !== 35) begin
            tests_failed++; $display("FAIL busy_start_ignored: got pulses %0d %h_%h busy %0d expected 1 00000000_00000036 35", np, hi, lo, bn);
        end
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, hi, lo, lat, bn, np);
        tests_run++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
            tests_failed++; $display("FAIL mult_min_sq: got %h_%h expected 40000000_00000000", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hi, lo; int lat, bn, np, pulses;
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before_rst: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || wr_en !== 2'b00 || wr_hdata !== 32'd0 || wr_ldata !== 32'd0) begin
            tests_failed++; $display("FAIL mid_rst_clear: got busy %b wr_en %b %h_%h expected 0 00 0_0", busy, wr_en, wr_hdata, wr_ldata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (wr_en != 2'b00 || busy) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin tests_failed++; $display("FAIL mid_rst_no_write: got %0d active cycles expected 0", pulses); end
        run_op(2'b01, 32'd3, 32'd4, 0, hi, lo, lat, bn, np);
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd12 || lat !== 35) begin
            tests_failed++; $display("FAIL post_rst_multu: got %h_%h lat %0d expected 00000000_0000000c lat 35", hi, lo, lat);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
        mt_en = 2'b00; mt_data = 32'd0;
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div_signed();
        test_divu();
        test_mt();
        test_start_wins();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit that produces the 64-bit results stored in the HI/LO register pair. It executes MULT, MULTU, DIV and DIVU with a radix-2 shift/add or subtract datapath, and forwards MTHI/MTLO writes. It drives the HI/LO write port directly. It sits in the execute stage; the pipeline stalls any HI/LO access while `busy` is high.

## Interface
Parameters:
- none; the iteration count and opcodes are fixed in the package.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — launches an operation; sampled only when `busy`=0.
- `op`  in  2  — 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `src_a`  in  32  — multiplicand or dividend (rs).
- `src_b`  in  32  — multiplier or divisor (rt).
- `mt_en`  in  2  — bit0 = MTLO, bit1 = MTHI; honoured only when idle and `start`=0.
- `mt_data`  in  32  — MTHI/MTLO data.
- `busy`  out  1  — operation in flight, registered.
- `wr_en`  out  2  — HI/LO write enable (bit1 = HI, bit0 = LO); one-cycle pulse.
- `wr_hdata`  out  32  — HI write data.
- `wr_ldata`  out  32  — LO write data.

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - `start`=1 → latch `op` and operands, go to PREP.
  - Else if `mt_en`≠0 → next cycle `wr_en`=`mt_en`, `wr_hdata`=`wr_ldata`=`mt_data`; stay in IDLE; `busy` stays 0.
  - `start` and `mt_en` together: `start` wins and the MT write is dropped.
- PREP:
  - Signed ops replace operands with absolute values (33-bit safe) and record the result signs.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- CALC: exactly 32 iterations, counter 0..31.
  - Multiply: shift/add into a 64-bit accumulator.
  - Divide: restoring algorithm; 32-bit remainder and quotient.
- FIX: conditional two's-complement negation of the product, or of quotient and remainder separately.
- DONE: `wr_en`=11; HI=product[63:32] or remainder; LO=product[31:0] or quotient. Then go to IDLE.
- Divide by zero needs no special case; the restoring algorithm itself yields LO=0xFFFFFFFF, HI=|a| with remainder sign fix, i.e. HI=`src_a`.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no trap.
- `start` while `busy` is ignored. `mt_en` while `busy` is ignored.
- Reset values: `busy`=0, `wr_en`=00, `wr_hdata`=`wr_ldata`=0, FSM=IDLE, counter=0.

## Timing
- `start` accepted at edge N:
  - PREP at N+1.
  - CALC during N+2..N+33.
  - FIX at N+34.
  - DONE at N+35, when `wr_en`=11 is visible for exactly one cycle.
- `busy` is high from N+1 through N+35 inclusive; a new `start` is accepted at N+36.
- An MT write is visible one cycle after it is sampled.
- `rst` asserted at any time (including mid-CALC) clears all state and outputs immediately; no partial write is ever issued.

## Configuration
- `MIPS_MULDIV_EARLY_EN` defined: multiply CALC exits to FIX as soon as the remaining multiplier bits are all zero. Latency is variable (minimum 4 cycles: start → PREP → FIX → DONE for multiplier 0). Divide latency is unchanged.
- Not defined: fixed 35-cycle latency for all ops.

## Structure
- Package `mips_muldiv_pkg`: op encodings, FSM state enum, ITER=32, counter width 5, `wr_en` bit positions (HI=1, LO=0).
- One sub-module: `mips_muldiv_sign`, a combinational conditional negate/absolute-value helper. It is instantiated for operand preparation (PREP) and result fix-up (FIX).

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → single `wr_en`=11 pulse 35 cycles after `start`, HI=0xFFFFFFFE, LO=0x00000001; `busy` high for 35 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5 / 0 → LO=0xFFFFFFFF, HI=0x00000005. DIVU 0x80000000 / 0xFFFFFFFF → LO=0, HI=0x80000000.
- While idle, `mt_en`=01, `mt_data`=0x00001234 → next cycle `wr_en`=01, `wr_ldata`=0x00001234. A second `start` issued mid-operation is ignored and produces only one write pulse.
- Assert `rst` at cycle N+20 of a DIV → `busy`, `wr_en` and data outputs are 0 immediately and no write pulse follows. A subsequent MULTU 3×4 gives HI=0, LO=12.
